// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle for ring_johnson_counter: step/load controls in,
// pattern, decoded position and wrap/err strobes out.
interface ring_johnson_counter_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2 * WIDTH);

  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [PW-1:0] load_pos;
  logic [WIDTH-1:0] out;
  logic [PW-1:0] pos;
  logic          wrap;
  logic          err;

  modport master (
    output en, dir, mode, load, load_pos,
    input  out, pos, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_pos,
    output out, pos, wrap, err
  );
endinterface

// File: rtl/ring_johnson_counter.sv
// Ring (one-hot) / Johnson (twisted-ring) sequencer with direction, parallel
// load, position decode, illegal-state recovery and end-of-period wrap strobe.
module ring_johnson_counter #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ring_johnson_counter_if.slave  bus
);
  localparam int PW = $clog2(2 * WIDTH);
  localparam logic [PW:0] W_EXT  = (PW + 1)'(WIDTH);
  localparam logic [PW:0] W2_EXT = (PW + 1)'(2 * WIDTH);

  logic [WIDTH-1:0] out_reg, out_next;
  logic             mode_q_reg, mode_q_next;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;

  logic [PW:0]      lp_ext;
  logic [WIDTH-1:0] ring_pat, john_lo_pat, john_hi_pat, load_pat;
  logic             load_bad;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-2:0] edges;
  logic [PW-1:0]    pc;
  logic             legal;
  logic [PW-1:0]    pos_c;

  function automatic logic [WIDTH-1:0] init_of(input logic m);
    return m ? '0 : WIDTH'(1);
  endfunction

  assign lp_ext = {1'b0, bus.load_pos};

  // Johnson positions above WIDTH fill from the top: bit i set iff i >= lp - WIDTH.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pat
    assign ring_pat[gi]    = (lp_ext == (PW + 1)'(gi));
    assign john_lo_pat[gi] = ((PW + 1)'(gi) < lp_ext);
    assign john_hi_pat[gi] = (((PW + 1)'(gi) + W_EXT) >= lp_ext);
  end

  always_comb begin
    load_pat = '0;
    load_bad = 1'b0;
    if (bus.mode) begin
      load_bad = (lp_ext >= W2_EXT);
      load_pat = (lp_ext <= W_EXT) ? john_lo_pat : john_hi_pat;
    end else begin
      load_bad = (lp_ext >= W_EXT);
      load_pat = ring_pat;
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PW'(out_reg[i]);
    end
  end

  // A legal Johnson word has at most one boundary between adjacent bits.
  assign edges = out_reg[WIDTH-2:0] ^ out_reg[WIDTH-1:1];
  assign legal = mode_q_reg ? ((edges & (edges - (WIDTH - 1)'(1))) == '0)
                            : (pc == PW'(1));

  always_comb begin
    shift_val = out_reg;
    case ({mode_q_reg, bus.dir})
      2'b00:   shift_val = {out_reg[WIDTH-2:0], out_reg[WIDTH-1]};
      2'b01:   shift_val = {out_reg[0], out_reg[WIDTH-1:1]};
      2'b10:   shift_val = {out_reg[WIDTH-2:0], ~out_reg[WIDTH-1]};
      default: shift_val = {~out_reg[0], out_reg[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    pos_c = '0;
    if (mode_q_reg) begin
      if (out_reg[0]) begin
        pos_c = pc;
      end else if (pc != '0) begin
        pos_c = PW'(2 * WIDTH) - pc;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (out_reg[i]) begin
          pos_c = PW'(i);
        end
      end
    end
  end

  always_comb begin
    out_next    = out_reg;
    mode_q_next = mode_q_reg;
    wrap_next   = 1'b0;
    err_next    = 1'b0;
    if (bus.load) begin
      mode_q_next = bus.mode;
      if (load_bad) begin
        out_next = init_of(bus.mode);
        err_next = 1'b1;
      end else begin
        out_next = load_pat;
      end
    end else if (bus.mode != mode_q_reg) begin
      mode_q_next = bus.mode;
      out_next    = init_of(bus.mode);
    end else if (!legal) begin
      out_next = init_of(mode_q_reg);
      err_next = 1'b1;
    end else if (bus.en) begin
      out_next  = shift_val;
      wrap_next = (shift_val == init_of(mode_q_reg));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg    <= WIDTH'(1);
      mode_q_reg <= 1'b0;
      wrap_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      out_reg    <= out_next;
      mode_q_reg <= mode_q_next;
      wrap_reg   <= wrap_next;
      err_reg    <= err_next;
    end
  end

  assign bus.out  = out_reg;
  assign bus.pos  = pos_c;
  assign bus.wrap = wrap_reg;
  assign bus.err  = err_reg;
endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter (WIDTH=4): a vector table of
// per-cycle inputs/expected outputs plus hand-written illegal-state and reset cases.
module tb_ring_johnson_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ring_johnson_counter_if #(.WIDTH(4)) bus_if ();
  ring_johnson_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic       en, dir, mode, load;
    logic [2:0] lp;
    logic [3:0] eo;
    logic [2:0] ep;
    logic       ew, ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, dir, mode, load, input logic [2:0] lp,
                              input logic [3:0] eo, input logic [2:0] ep, input logic ew, ee);
    vec_t v;
    v.en = en; v.dir = dir; v.mode = mode; v.load = load; v.lp = lp;
    v.eo = eo; v.ep = ep; v.ew = ew; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, dir, mode, load, input logic [2:0] lp);
    bus_if.en = en; bus_if.dir = dir; bus_if.mode = mode;
    bus_if.load = load; bus_if.load_pos = lp;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);

    // ring forward, mode switch, Johnson full period, reverse, hold, dir flip
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,3,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,1,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0000,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0001,1,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0011,2,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0111,3,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b1111,4,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b1110,5,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b1100,6,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b1000,7,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0000,0,1,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0001,1,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0011,2,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0111,3,0,0));
    vecs.push_back(mk(1,1,1,0,0, 4'b0011,2,0,0));
    vecs.push_back(mk(1,1,1,0,0, 4'b0001,1,0,0));
    vecs.push_back(mk(1,1,1,0,0, 4'b0000,0,1,0));
    vecs.push_back(mk(0,1,1,0,0, 4'b0000,0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 4'b0000,0,0,0));
    vecs.push_back(mk(1,1,1,0,0, 4'b1000,7,0,0));
    vecs.push_back(mk(1,0,1,0,0, 4'b0000,0,1,0));
    // loads: with mode change, out-of-range, ring reverse wrap, Johnson patterns
    vecs.push_back(mk(0,0,0,1,2, 4'b0100,2,0,0));
    vecs.push_back(mk(0,0,0,1,5, 4'b0001,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 4'b0001,0,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1000,3,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b0100,2,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b0010,1,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b0001,0,1,0));
    vecs.push_back(mk(0,0,1,1,6, 4'b1100,6,0,0));
    vecs.push_back(mk(0,0,1,1,3, 4'b0111,3,0,0));
    vecs.push_back(mk(1,0,1,1,0, 4'b0000,0,0,0));
    vecs.push_back(mk(0,0,1,1,4, 4'b1111,4,0,0));
    vecs.push_back(mk(0,0,1,1,7, 4'b1000,7,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,0,0));
    vecs.push_back(mk(0,0,0,1,3, 4'b1000,3,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,1,0));
    vecs.push_back(mk(1,0,0,1,0, 4'b0001,0,0,0));
    vecs.push_back(mk(0,0,0,1,4, 4'b0001,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 4'b0001,0,0,0));

    @(negedge clk);
    @(negedge clk);
    check("reset_out",  32'(bus_if.out),  32'h1);
    check("reset_pos",  32'(bus_if.pos),  32'h0);
    check("reset_wrap", 32'(bus_if.wrap), 32'h0);
    check("reset_err",  32'(bus_if.err),  32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lp);
      @(negedge clk);
      $display("vec %0d: en=%b dir=%b mode=%b load=%b lp=%0d -> out=%b pos=%0d wrap=%b err=%b",
               i, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lp,
               bus_if.out, bus_if.pos, bus_if.wrap, bus_if.err);
      check($sformatf("vec%0d_out", i),  32'(bus_if.out),  32'(vecs[i].eo));
      check($sformatf("vec%0d_pos", i),  32'(bus_if.pos),  32'(vecs[i].ep));
      check($sformatf("vec%0d_wrap", i), 32'(bus_if.wrap), 32'(vecs[i].ew));
      check($sformatf("vec%0d_err", i),  32'(bus_if.err),  32'(vecs[i].ee));
    end

    // ring: deposit illegal 0110, expect correction strobe, then INIT
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    check("ring_pre_force_out", 32'(bus_if.out), 32'b0010);
    force dut.out_reg = 4'b0110;
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1 release dut.out_reg;
    bus_if.en = 1'b0;
    @(negedge clk);
    check("ring_illegal_err",  32'(bus_if.err),  32'h1);
    check("ring_illegal_wrap", 32'(bus_if.wrap), 32'h0);
    @(negedge clk);
    check("ring_illegal_out", 32'(bus_if.out), 32'b0001);
    check("ring_illegal_pos", 32'(bus_if.pos), 32'h0);
    $display("ring illegal 0110 -> out=%b err seen", bus_if.out);

    // Johnson: deposit illegal 0101
    drive(0, 0, 1, 1, 2);
    @(negedge clk);
    check("john_pre_force_out", 32'(bus_if.out), 32'b0011);
    force dut.out_reg = 4'b0101;
    drive(1, 0, 1, 0, 0);
    @(posedge clk);
    #1 release dut.out_reg;
    bus_if.en = 1'b0;
    @(negedge clk);
    check("john_illegal_err",  32'(bus_if.err),  32'h1);
    check("john_illegal_wrap", 32'(bus_if.wrap), 32'h0);
    @(negedge clk);
    check("john_illegal_out", 32'(bus_if.out), 32'b0000);
    $display("johnson illegal 0101 -> out=%b", bus_if.out);

    // async reset mid-Johnson at 1110, observed before the next clock edge
    drive(0, 0, 1, 1, 5);
    @(negedge clk);
    check("john_load5_out", 32'(bus_if.out), 32'b1110);
    check("john_load5_pos", 32'(bus_if.pos), 32'h5);
    bus_if.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out",  32'(bus_if.out),  32'b0001);
    check("async_rst_pos",  32'(bus_if.pos),  32'h0);
    check("async_rst_wrap", 32'(bus_if.wrap), 32'h0);
    check("async_rst_err",  32'(bus_if.err),  32'h0);
    $display("async reset -> out=%b pos=%0d", bus_if.out, bus_if.pos);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_first_shift", 32'(bus_if.out), 32'b0010);
    check("post_rst_pos",         32'(bus_if.pos), 32'h1);
    $display("first shift after reset -> out=%b", bus_if.out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
